// File: rtl/nn_io_pkg.sv
// Shared types, default feature-vector geometry and a width helper for the
// network I/O blocks. No ports; imported by nn_frame_loader and launch_timer.
// Latency/backpressure: not applicable (package only).
package nn_io_pkg;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } loader_state_e;

  localparam int NN_FEAT_W    = 16;
  localparam int NN_FEAT_FRAC = 10;
  localparam int NN_N_FEAT    = 16;

  // Bits needed to index n entries; never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nn_frame_loader_launch_timer.sv
// launch_timer: spacing counter between frame launches.
// Latency: start loads LAUNCH_INTERVAL-1; expired is high LAUNCH_INTERVAL-1 cycles later.
// Backpressure: none; counts down one per cycle while nonzero.
// Ports: clk, reset (sync, active-high), start (load pulse), expired (count is zero).
module launch_timer
  import nn_io_pkg::*;
#(
  parameter int LAUNCH_INTERVAL = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic expired
);

  localparam int CW = $clog2(LAUNCH_INTERVAL) + 1;
  localparam logic [CW-1:0] RELOAD = CW'(LAUNCH_INTERVAL - 1);

  logic [CW-1:0] icnt_q, icnt_d;

  always_comb begin
    icnt_d = icnt_q;
    if (start) begin
      icnt_d = RELOAD;
    end else if (icnt_q != '0) begin
      icnt_d = icnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      icnt_q <= '0;
    end else begin
      icnt_q <= icnt_d;
    end
  end

  assign expired = (icnt_q == '0);

endmodule

// File: rtl/nn_frame_loader.sv
// nn_frame_loader: assembles a valid/ready word stream into an N_FEAT vector and
// launches it with a one-cycle input_ready pulse; input_data holds until the next launch.
// Latency: launch one edge after the final beat when the launch timer has expired.
// Backpressure: s_ready low (state decode only) while a full frame awaits launch.
// Ports: clk, reset (sync, active-high); s_valid/s_ready/s_data/s_last stream in;
//   input_ready, input_data[N_FEAT-1:0], frame_err, frames_launched out.
// Optional: define FRAME_LAST_CHECK_EN to validate s_last against the word count.
module nn_frame_loader
  import nn_io_pkg::*;
#(
  parameter int WIDTH           = NN_FEAT_W,
  parameter int NFRAC           = NN_FEAT_FRAC,
  parameter int N_FEAT          = NN_N_FEAT,
  parameter int LAUNCH_INTERVAL = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [WIDTH-1:0] s_data,
  input  logic                    s_last,
  output logic                    input_ready,
  output logic signed [WIDTH-1:0] input_data [N_FEAT-1:0],
  output logic                    frame_err,
  output logic [15:0]             frames_launched
);

  localparam int IDX_W = idx_width(N_FEAT);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_FEAT - 1);
  // Fraction position is a property of the data only; nothing here depends on it.
  localparam int unused_nfrac = NFRAC;

  loader_state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic signed [WIDTH-1:0] fbuf_q [N_FEAT-1:0];
  logic signed [WIDTH-1:0] fbuf_d [N_FEAT-1:0];
  logic signed [WIDTH-1:0] launch_q [N_FEAT-1:0];
  logic signed [WIDTH-1:0] launch_d [N_FEAT-1:0];
  logic input_ready_q, input_ready_d;
  logic [15:0] count_q, count_d;
  logic beat;
  logic timer_start;
  logic expired;

`ifdef FRAME_LAST_CHECK_EN
  logic frame_err_q, frame_err_d;
`else
  logic unused_last;
  assign unused_last = s_last;
`endif

  launch_timer #(
    .LAUNCH_INTERVAL(LAUNCH_INTERVAL)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .start  (timer_start),
    .expired(expired)
  );

  // Ready is a pure state decode, forced low while reset is held.
  assign s_ready = (state_q == FILL) && !reset;
  assign beat    = s_valid && (state_q == FILL);

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    fbuf_d        = fbuf_q;
    launch_d      = launch_q;
    input_ready_d = 1'b0;
    count_d       = count_q;
    timer_start   = 1'b0;
`ifdef FRAME_LAST_CHECK_EN
    frame_err_d   = 1'b0;
`endif
    case (state_q)
      FILL: begin
        if (beat) begin
          // A rejected word may land in fbuf; idx restarts at 0 so every
          // entry is rewritten before the buffer can be launched.
          fbuf_d[idx_q] = s_data;
          if (idx_q == IDX_MAX) begin
            idx_d   = '0;
            state_d = FULL;
          end else begin
            idx_d = idx_q + 1'b1;
          end
`ifdef FRAME_LAST_CHECK_EN
          if (s_last && (idx_q != IDX_MAX)) begin
            frame_err_d = 1'b1;
            idx_d       = '0;
          end else if (!s_last && (idx_q == IDX_MAX)) begin
            frame_err_d = 1'b1;
            state_d     = FILL;
          end
`endif
        end
      end
      FULL: begin
        if (expired) begin
          launch_d      = fbuf_q;
          input_ready_d = 1'b1;
          timer_start   = 1'b1;
          count_d       = count_q + 16'd1;
          state_d       = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FILL;
      idx_q         <= '0;
      launch_q      <= '{default: '0};
      input_ready_q <= 1'b0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      launch_q      <= launch_d;
      input_ready_q <= input_ready_d;
      count_q       <= count_d;
    end
  end

  // Fill buffer needs no reset: it is fully rewritten before any launch.
  always_ff @(posedge clk) begin
    fbuf_q <= fbuf_d;
  end

`ifdef FRAME_LAST_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
    end
  end
  assign frame_err = frame_err_q;
`else
  assign frame_err = 1'b0;
`endif

  assign input_ready     = input_ready_q;
  assign input_data      = launch_q;
  assign frames_launched = count_q;

endmodule

// File: tb/tb_nn_frame_loader.sv
// Bench for nn_frame_loader: two instances (LAUNCH_INTERVAL 8 and 40) driven by a
// table of frame scenarios plus hand-written error and reset sequences, with a
// frame-level reference model checking every output on every cycle.
module tb_nn_frame_loader;
  localparam int W   = 16;
  localparam int N   = 16;
  localparam int LI0 = 8;
  localparam int LI1 = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic s_valid [2];
  logic s_ready [2];
  logic signed [W-1:0] s_data [2];
  logic s_last [2];
  logic input_ready [2];
  logic frame_err [2];
  logic [15:0] frames_launched [2];
  logic signed [W-1:0] input_data0 [N-1:0];
  logic signed [W-1:0] input_data1 [N-1:0];

  nn_frame_loader #(.WIDTH(W), .NFRAC(10), .N_FEAT(N), .LAUNCH_INTERVAL(LI0)) dut0 (
    .clk(clk), .reset(reset), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
    .s_data(s_data[0]), .s_last(s_last[0]), .input_ready(input_ready[0]),
    .input_data(input_data0), .frame_err(frame_err[0]), .frames_launched(frames_launched[0]));

  nn_frame_loader #(.WIDTH(W), .NFRAC(10), .N_FEAT(N), .LAUNCH_INTERVAL(LI1)) dut1 (
    .clk(clk), .reset(reset), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
    .s_data(s_data[1]), .s_last(s_last[1]), .input_ready(input_ready[1]),
    .input_data(input_data1), .frame_err(frame_err[1]), .frames_launched(frames_launched[1]));

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s: no DUT response within cycle budget (cycle %0d)", name, cyc);
  endtask

  function automatic logic signed [W-1:0] dout(input int sel, input int k);
    return (sel == 0) ? input_data0[k] : input_data1[k];
  endfunction

  function automatic int li(input int sel);
    return (sel == 0) ? LI0 : LI1;
  endfunction

  // Reference model: frame-level bookkeeping. A completed frame launches at
  // max(final beat edge + 1, previous launch edge + LAUNCH_INTERVAL).
  logic signed [W-1:0] acc_w [2][N];
  logic signed [W-1:0] pend_w [2][N];
  logic signed [W-1:0] hold [2][N];
  int acc_n [2], nl [2], last_l [2], pend_edge [2], err_edge [2];
  bit pend_v [2], rst_pend [2];
  bit chk_en = 0;
  int obs_prev [2], gap_min [2], gap_max [2], err_seen [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      acc_n[i] = 0; nl[i] = 0; last_l[i] = -1000; pend_edge[i] = -1; err_edge[i] = -1;
      pend_v[i] = 0; rst_pend[i] = 0; obs_prev[i] = -1; gap_min[i] = 1 << 30;
      gap_max[i] = 0; err_seen[i] = 0;
    end
  end

  always @(negedge clk) begin : mon
    int kk;
    bit exp_rdy;
    for (int i = 0; i < 2; i++) begin
      if (rst_pend[i]) begin
        acc_n[i] = 0; pend_v[i] = 0; nl[i] = 0; last_l[i] = -1000; err_edge[i] = -1;
        for (int k = 0; k < N; k++) hold[i][k] = '0;
        chk_en = 1;
      end else if (pend_v[i] && pend_edge[i] == cyc) begin
        hold[i] = pend_w[i];
        nl[i]++;
        last_l[i] = cyc;
        pend_v[i] = 0;
      end
      exp_rdy = !pend_v[i] && !reset;
      if (chk_en) begin
        check($sformatf("dut%0d input_ready", i), input_ready[i], (last_l[i] == cyc));
        check($sformatf("dut%0d frame_err", i), frame_err[i], (err_edge[i] == cyc));
        check($sformatf("dut%0d frames_launched", i), frames_launched[i], nl[i] & 16'hFFFF);
        check($sformatf("dut%0d s_ready", i), s_ready[i], exp_rdy);
        kk = 0;
        for (int k = N - 1; k >= 0; k--) if (dout(i, k) !== hold[i][k]) kk = k;
        check($sformatf("dut%0d input_data[%0d]", i, kk), dout(i, kk), hold[i][kk]);
        if (input_ready[i] === 1'b1) begin
          if (obs_prev[i] >= 0) begin
            if (cyc - obs_prev[i] < gap_min[i]) gap_min[i] = cyc - obs_prev[i];
            if (cyc - obs_prev[i] > gap_max[i]) gap_max[i] = cyc - obs_prev[i];
          end
          obs_prev[i] = cyc;
        end
        if (frame_err[i] === 1'b1) err_seen[i]++;
      end
      rst_pend[i] = reset;
      // A beat seen now takes effect at edge cyc+1.
      if (exp_rdy && s_valid[i]) begin
`ifdef FRAME_LAST_CHECK_EN
        if ((s_last[i] && acc_n[i] < N - 1) || (!s_last[i] && acc_n[i] == N - 1)) begin
          err_edge[i] = cyc + 1;
          acc_n[i] = 0;
        end else
`endif
        begin
          acc_w[i][acc_n[i]] = s_data[i];
          acc_n[i]++;
          if (acc_n[i] == N) begin
            pend_w[i] = acc_w[i];
            pend_v[i] = 1;
            pend_edge[i] = (cyc + 2 > last_l[i] + li(i)) ? cyc + 2 : last_l[i] + li(i);
            acc_n[i] = 0;
          end
        end
      end
    end
  end

  logic signed [W-1:0] sent [N];

  task automatic send_word(input int sel, input logic signed [W-1:0] d, input bit l,
                           input int stall, output bit ok);
    int waited = 0;
    bit done = 0;
    ok = 1;
    while (!done) begin
      s_data[sel] = d;
      s_last[sel] = l;
      s_valid[sel] = ($urandom_range(99) >= stall);
      @(negedge clk);
      if (s_valid[sel] && s_ready[sel] === 1'b1) done = 1;
      @(posedge clk);
      #1;
      s_valid[sel] = 1'b0;
      waited++;
      if (!done && waited > 100) begin
        fail_now($sformatf("dut%0d beat_timeout", sel));
        ok = 0;
        return;
      end
    end
  endtask

  task automatic send_frame(input int sel, input int nw, input int last_pos, input int base,
                            input bit rnd, input int stall);
    logic signed [W-1:0] d;
    bit ok;
    for (int k = 0; k < nw; k++) begin
      d = rnd ? W'($urandom) : W'(base + k);
      if (k < N) sent[k] = d;
      send_word(sel, d, (k == last_pos), stall, ok);
      if (!ok) return;
    end
  endtask

  task automatic wait_idle(input int sel);
    int n = 0;
    while (pend_v[sel] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (pend_v[sel]) fail_now($sformatf("dut%0d launch_timeout", sel));
    @(posedge clk);
    #1;
  endtask

  task automatic check_sent(input string name, input int sel);
    int kk = 0;
    for (int k = N - 1; k >= 0; k--) if (dout(sel, k) !== sent[k]) kk = k;
    check($sformatf("%s data[%0d]", name, kk), dout(sel, kk), sent[kk]);
  endtask

  typedef struct {
    int sel;
    int nframes;
    int stall;
    bit rnd;
    int base;
    int exp_gap;
    int exp_count;
  } vec_t;

  vec_t tv [5];

  initial begin : stim
    tv[0] = '{sel: 0, nframes: 1, stall: 0,  rnd: 0, base: 1,     exp_gap: 0,  exp_count: 1};
    tv[1] = '{sel: 0, nframes: 3, stall: 0,  rnd: 0, base: 100,   exp_gap: 17, exp_count: 4};
    tv[2] = '{sel: 1, nframes: 2, stall: 0,  rnd: 0, base: -50,   exp_gap: 40, exp_count: 2};
    tv[3] = '{sel: 0, nframes: 4, stall: 50, rnd: 1, base: 0,     exp_gap: 0,  exp_count: 8};
    tv[4] = '{sel: 1, nframes: 3, stall: 50, rnd: 1, base: 0,     exp_gap: 0,  exp_count: 5};

    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      s_valid[i] = 1'b0; s_data[i] = '0; s_last[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    for (int t = 0; t < 5; t++) begin
      obs_prev[tv[t].sel] = -1;
      gap_min[tv[t].sel] = 1 << 30;
      gap_max[tv[t].sel] = 0;
      for (int f = 0; f < tv[t].nframes; f++)
        send_frame(tv[t].sel, N, N - 1, tv[t].base + f * N, tv[t].rnd, tv[t].stall);
      wait_idle(tv[t].sel);
      check($sformatf("vec%0d frames_launched", t), frames_launched[tv[t].sel], tv[t].exp_count);
      check_sent($sformatf("vec%0d", t), tv[t].sel);
      if (tv[t].exp_gap != 0) begin
        check($sformatf("vec%0d min_gap", t), gap_min[tv[t].sel], tv[t].exp_gap);
        check($sformatf("vec%0d max_gap", t), gap_max[tv[t].sel], tv[t].exp_gap);
      end
    end

    // s_last handling on dut0 (8 frames launched so far).
`ifdef FRAME_LAST_CHECK_EN
    send_frame(0, 5, 4, 500, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    check("early_last frame_err count", err_seen[0], 1);
    check("early_last frames_launched", frames_launched[0], 8);
    send_frame(0, N, N - 1, 600, 0, 0);
    wait_idle(0);
    check("after_err frames_launched", frames_launched[0], 9);
    check_sent("after_err", 0);
    send_frame(0, N, -1, 700, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    check("missing_last frame_err count", err_seen[0], 2);
    check("missing_last frames_launched", frames_launched[0], 9);
`else
    send_frame(0, N, 4, 600, 0, 0);
    wait_idle(0);
    check("ignored_last frames_launched", frames_launched[0], 9);
    check_sent("ignored_last", 0);
    check("ignored_last frame_err count", err_seen[0], 0);
`endif

    // Reset after 9 beats of a frame.
    send_frame(0, 9, -1, 900, 0, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst s_ready", s_ready[0], 0);
    check("rst frames_launched", frames_launched[0], 0);
    check("rst input_data[0]", input_data0[0], 0);
    check("rst input_ready", input_ready[0], 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post_rst s_ready", s_ready[0], 1);
    @(posedge clk);
    #1;
    send_frame(0, N, N - 1, 1000, 0, 0);
    wait_idle(0);
    check("post_rst frames_launched", frames_launched[0], 1);
    check_sent("post_rst", 0);

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin : watchdog
    #800000;
    $display("FAIL global_timeout: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "global timeout");
  end

endmodule
